alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Sink-side counterpart to the ALU stimulus generator. Accepts one ALU result per cycle (DATA_OUT and ZERO) through a valid/ready handshake.
- Buffers results in a FIFO so a slower consumer can drain them: the data_sink bench block, or a future memory-writeback port.
- Compacts every accepted result into a 32-bit MISR signature for self-checking.
- Keeps result and zero-flag counters, so a full ALU regression can be checked against a single golden signature.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the result and zero counters.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'h00000000, MISR value after reset or clear.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- CLEAR  in  1  synchronous clear of FIFO, counters, signature and OVERFLOW.
- IN_VALID  in  1  ALU result valid.
- IN_READY  out  1  collector can accept; equals !FULL.
- DATA_IN  in  32  ALU DATA_OUT.
- ZERO_IN  in  1  ALU ZERO flag.
- OUT_VALID  out  1  FIFO head valid; equals !EMPTY.
- OUT_READY  in  1  consumer pops the head.
- OUT_DATA  out  32  head result.
- OUT_ZERO  out  1  head zero flag.
- SIGNATURE  out  32  current MISR value.
- RES_COUNT  out  CNT_W  accepted results.
- ZERO_COUNT  out  CNT_W  accepted results with ZERO_IN=1.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.
- OVERFLOW  out  1  sticky; a result was offered while full.

Behaviour:
- Reset (RST_n=0, asynchronous): pointers and occupancy 0, EMPTY=1, FULL=0, OUT_VALID=0, IN_READY=1, SIGNATURE=SEED, both counters 0, OVERFLOW=0. OUT_DATA/OUT_ZERO read entry 0; its value is don't-care while EMPTY.
- Push happens when IN_VALID && IN_READY at a rising edge. The entry {ZERO_IN, DATA_IN} is written at wptr, then wptr increments and wraps modulo DEPTH.
- Pop happens when OUT_VALID && OUT_READY. rptr increments and wraps modulo DEPTH.
- No bypass. A result accepted in cycle N appears on OUT_* in cycle N+1 at the earliest.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance. When full, IN_READY=0, so no push is taken even if a pop occurs that cycle. When empty, no pop is possible.
- Occupancy is tracked with an extra pointer bit or an explicit counter. FULL when occupancy==DEPTH; EMPTY when occupancy==0.
- MISR updates only on a push: SIG' = (SIG<<1 truncated to 32 bits) ^ (SIG[31] ? POLY : 0) ^ DATA_IN ^ {31'b0, ZERO_IN}.
- RES_COUNT increments on every push. ZERO_COUNT increments on a push with ZERO_IN=1. Both saturate at all-ones and do not wrap.
- Overflow: IN_VALID=1 while FULL sets OVERFLOW at that edge. The offered sample is dropped and is not folded into the MISR or counters. OVERFLOW stays set until reset or CLEAR.
- CLEAR=1 at an edge: same state as reset. It takes priority over a simultaneous push or pop, and neither takes effect.
- Reset asserted mid-stream discards all buffered entries immediately.
- All outputs are registered or decoded from registers only. There are no combinational paths from IN_* to OUT_* or to IN_READY.

Decomposition:
- Shared package alu_tb_pkg holds:
  - RES_W=32 and the ALU CTRL opcode constants already used by the stimulus side.
  - MISR_POLY_DEFAULT.
  - a function misr_step(sig, data, zero) used by both the RTL and the bench golden model.
- One natural sub-module, result_fifo: parameterized synchronous FIFO, DEPTH x 33 bits, with push/pop/full/empty.
- The MISR and counters stay in the top level.

Test Plan:
- Reset then 3 pushes with SEED=0 and default POLY: (0x00000001, Z=0), (0x80000000, Z=0), (0x00000000, Z=1), OUT_READY=0.
  - SIGNATURE after each push: 0x00000001, 0x80000002, 0x04C11DB2.
  - RES_COUNT=3, ZERO_COUNT=1.
  - OUT_VALID rises 1 cycle after the first push, and OUT_DATA=0x00000001.
- Fill with 8 pushes of values 0..7, OUT_READY=0.
  - FULL=1 and IN_READY=0.
  - A 9th IN_VALID with 0xDEADBEEF sets OVERFLOW=1; SIGNATURE and RES_COUNT are unchanged.
  - Draining returns 0..7 in order, and EMPTY=1 afterwards.
- Continuous push and pop with OUT_READY=1 for 20 cycles:
  - occupancy is steady at 1 with no FULL.
  - pointers wrap twice.
  - output sequence equals the input sequence delayed 1 cycle.
- With the FIFO full, assert IN_VALID and OUT_READY in the same cycle:
  - a pop occurs and no push occurs.
  - the next cycle shows FULL=0 and IN_READY=1.
- Assert CLEAR in the same cycle as a push, with 4 entries buffered and OVERFLOW=1:
  - EMPTY=1, SIGNATURE=SEED, both counters 0, OVERFLOW=0.
  - the pushed sample is lost.
- Assert RST_n=0 asynchronously mid-cycle during a burst:
  - outputs return to reset values before the next CLK edge.
  - pushes after release restart the signature from SEED.

Source files
------------

// File: rtl/alu_tb_pkg.sv
// Shared ALU test definitions: result width, CTRL opcodes, and the MISR step
// function used by the collector and its golden model.
package alu_tb_pkg;

  localparam int RES_W = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [RES_W-1:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

  // One MISR step: shift left, fold the polynomial on MSB carry-out, then
  // XOR in the result word with the zero flag on bit 0.
  function automatic logic [RES_W-1:0] misr_step(
    input logic [RES_W-1:0] sig,
    input logic [RES_W-1:0] data,
    input logic             zero,
    input logic [RES_W-1:0] poly = MISR_POLY_DEFAULT
  );
    logic [RES_W-1:0] nxt;
    nxt = {sig[RES_W-2:0], 1'b0};
    if (sig[RES_W-1]) nxt = nxt ^ poly;
    nxt = nxt ^ data ^ {{(RES_W-1){1'b0}}, zero};
    return nxt;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty; no bypass, so a
// pushed entry is visible on rdata_o one cycle later at the earliest.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU results through valid/ready, buffers them for a consumer, and
// keeps a MISR signature plus saturating result/zero counters.
module alu_result_collector
  import alu_tb_pkg::*;
#(
  parameter int               DEPTH = 8,
  parameter int               CNT_W = 16,
  parameter logic [RES_W-1:0] POLY  = MISR_POLY_DEFAULT,
  parameter logic [RES_W-1:0] SEED  = 32'h00000000
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             CLEAR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [RES_W-1:0] DATA_IN,
  input  logic             ZERO_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [RES_W-1:0] OUT_DATA,
  output logic             OUT_ZERO,
  output logic [RES_W-1:0] SIGNATURE,
  output logic [CNT_W-1:0] RES_COUNT,
  output logic [CNT_W-1:0] ZERO_COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVERFLOW
);

  // Handshake: a transfer happens on a rising edge where valid && ready; both
  // ready signals are decoded from FIFO state only, never from the inputs.
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             push, pop;
  logic [RES_W:0]   head;
  logic [RES_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d, zero_cnt_q, zero_cnt_d;
  logic             ovf_q, ovf_d;

  assign push = IN_VALID && !FULL && !CLEAR;
  assign pop  = OUT_READY && !EMPTY && !CLEAR;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (RES_W + 1)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .clear_i (CLEAR),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({ZERO_IN, DATA_IN}),
    .rdata_o (head),
    .full_o  (FULL),
    .empty_o (EMPTY)
  );

  assign IN_READY   = !FULL;
  assign OUT_VALID  = !EMPTY;
  assign OUT_DATA   = head[RES_W-1:0];
  assign OUT_ZERO   = head[RES_W];
  assign SIGNATURE  = sig_q;
  assign RES_COUNT  = res_cnt_q;
  assign ZERO_COUNT = zero_cnt_q;
  assign OVERFLOW   = ovf_q;

  always_comb begin
    sig_d      = sig_q;
    res_cnt_d  = res_cnt_q;
    zero_cnt_d = zero_cnt_q;
    ovf_d      = ovf_q;
    if (CLEAR) begin
      sig_d      = SEED;
      res_cnt_d  = '0;
      zero_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (push) begin
        sig_d = misr_step(sig_q, DATA_IN, ZERO_IN, POLY);
        if (res_cnt_q != '1) res_cnt_d = res_cnt_q + CNT_ONE;
        if (ZERO_IN && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + CNT_ONE;
      end
      // A sample offered while full is dropped; only the sticky flag records it.
      if (IN_VALID && FULL) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sig_q      <= SEED;
      res_cnt_q  <= '0;
      zero_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sig_q      <= sig_d;
      res_cnt_q  <= res_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: reset, MISR vectors, fill/overflow,
// streaming, full-with-pop, clear and asynchronous reset scenarios.
module tb_alu_result_collector;

  logic        CLK, RST_n, CLEAR, IN_VALID, IN_READY, ZERO_IN;
  logic        OUT_VALID, OUT_READY, OUT_ZERO, FULL, EMPTY, OVERFLOW;
  logic [31:0] DATA_IN, OUT_DATA, SIGNATURE;
  logic [15:0] RES_COUNT, ZERO_COUNT;

  int tests_run = 0;
  int tests_failed = 0;

  alu_result_collector dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .CLEAR      (CLEAR),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .DATA_IN    (DATA_IN),
    .ZERO_IN    (ZERO_IN),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_ZERO   (OUT_ZERO),
    .SIGNATURE  (SIGNATURE),
    .RES_COUNT  (RES_COUNT),
    .ZERO_COUNT (ZERO_COUNT),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .OVERFLOW   (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Independent golden MISR step with the default polynomial.
  function automatic logic [31:0] tb_misr(input logic [31:0] s, input logic [31:0] d,
                                          input logic z);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ 32'h04C11DB7;
    return r ^ d ^ {31'b0, z};
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b0; CLEAR = 1'b0; DATA_IN = '0; ZERO_IN = 1'b0;
    @(negedge CLK);
    RST_n = 1'b0;
    cycle();
    RST_n = 1'b1;
  endtask

  task automatic fill8(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      IN_VALID = 1'b1; DATA_IN = base + 32'(i); ZERO_IN = 1'b0;
      cycle();
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (EMPTY !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", EMPTY); end
    tests_run++; if (FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", FULL); end
    tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", OUT_VALID); end
    tests_run++; if (IN_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", IN_READY); end
    tests_run++; if (SIGNATURE !== 32'h0) begin tests_failed++; $display("FAIL reset_sig got %h exp 00000000", SIGNATURE); end
    tests_run++; if (RES_COUNT !== 16'd0) begin tests_failed++; $display("FAIL reset_res_count got %0d exp 0", RES_COUNT); end
    tests_run++; if (ZERO_COUNT !== 16'd0) begin tests_failed++; $display("FAIL reset_zero_count got %0d exp 0", ZERO_COUNT); end
    tests_run++; if (OVERFLOW !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", OVERFLOW); end
  endtask

  task automatic test_misr();
    do_reset();
    IN_VALID = 1'b1; DATA_IN = 32'h00000001; ZERO_IN = 1'b0;
    tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL misr_no_bypass got %b exp 0", OUT_VALID); end
    cycle();
    tests_run++; if (SIGNATURE !== 32'h00000001) begin tests_failed++; $display("FAIL misr_sig1 got %h exp 00000001", SIGNATURE); end
    tests_run++; if (OUT_VALID !== 1'b1) begin tests_failed++; $display("FAIL misr_out_valid got %b exp 1", OUT_VALID); end
    DATA_IN = 32'h80000000; ZERO_IN = 1'b0;
    cycle();
    tests_run++; if (SIGNATURE !== 32'h80000002) begin tests_failed++; $display("FAIL misr_sig2 got %h exp 80000002", SIGNATURE); end
    DATA_IN = 32'h00000000; ZERO_IN = 1'b1;
    cycle();
    IN_VALID = 1'b0; ZERO_IN = 1'b0;
    tests_run++; if (SIGNATURE !== 32'h04C11DB2) begin tests_failed++; $display("FAIL misr_sig3 got %h exp 04c11db2", SIGNATURE); end
    tests_run++; if (RES_COUNT !== 16'd3) begin tests_failed++; $display("FAIL misr_res_count got %0d exp 3", RES_COUNT); end
    tests_run++; if (ZERO_COUNT !== 16'd1) begin tests_failed++; $display("FAIL misr_zero_count got %0d exp 1", ZERO_COUNT); end
    tests_run++; if (OUT_DATA !== 32'h00000001 || OUT_ZERO !== 1'b0) begin tests_failed++; $display("FAIL misr_head got %h/%b exp 00000001/0", OUT_DATA, OUT_ZERO); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] exp_sig;
    do_reset();
    exp_sig = 32'h0;
    for (int i = 0; i < 8; i++) exp_sig = tb_misr(exp_sig, 32'(i), 1'b0);
    fill8(32'h0);
    tests_run++; if (FULL !== 1'b1 || IN_READY !== 1'b0) begin tests_failed++; $display("FAIL fill_full got full=%b rdy=%b exp 1/0", FULL, IN_READY); end
    tests_run++; if (SIGNATURE !== exp_sig) begin tests_failed++; $display("FAIL fill_sig got %h exp %h", SIGNATURE, exp_sig); end
    IN_VALID = 1'b1; DATA_IN = 32'hDEADBEEF;
    cycle();
    IN_VALID = 1'b0;
    tests_run++; if (OVERFLOW !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b exp 1", OVERFLOW); end
    tests_run++; if (SIGNATURE !== exp_sig) begin tests_failed++; $display("FAIL ovf_sig got %h exp %h", SIGNATURE, exp_sig); end
    tests_run++; if (RES_COUNT !== 16'd8) begin tests_failed++; $display("FAIL ovf_res_count got %0d exp 8", RES_COUNT); end
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'(i)) begin tests_failed++; $display("FAIL drain_%0d got v=%b d=%h exp 1/%h", i, OUT_VALID, OUT_DATA, 32'(i)); end
      cycle();
    end
    OUT_READY = 1'b0;
    tests_run++; if (EMPTY !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %b exp 1", EMPTY); end
    tests_run++; if (OVERFLOW !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b exp 1", OVERFLOW); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      IN_VALID = 1'b1; DATA_IN = 32'h100 + 32'(i); ZERO_IN = 1'b0;
      cycle();
      tests_run++; if ({OUT_VALID, FULL, EMPTY} !== 3'b100) begin tests_failed++; $display("FAIL b2b_occ_%0d got v/f/e=%b exp 100", i, {OUT_VALID, FULL, EMPTY}); end
      tests_run++; if (OUT_DATA !== 32'h100 + 32'(i)) begin tests_failed++; $display("FAIL b2b_data_%0d got %h exp %h", i, OUT_DATA, 32'h100 + 32'(i)); end
    end
    IN_VALID = 1'b0;
    cycle();
    OUT_READY = 1'b0;
    tests_run++; if (EMPTY !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got %b exp 1", EMPTY); end
    tests_run++; if (RES_COUNT !== 16'd20) begin tests_failed++; $display("FAIL b2b_res_count got %0d exp 20", RES_COUNT); end
  endtask

  task automatic test_full_pop();
    do_reset();
    fill8(32'h20);
    IN_VALID = 1'b1; DATA_IN = 32'h99; OUT_READY = 1'b1;
    cycle();
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    tests_run++; if (FULL !== 1'b0 || IN_READY !== 1'b1) begin tests_failed++; $display("FAIL fullpop_ready got full=%b rdy=%b exp 0/1", FULL, IN_READY); end
    tests_run++; if (OUT_DATA !== 32'h21) begin tests_failed++; $display("FAIL fullpop_head got %h exp 00000021", OUT_DATA); end
    tests_run++; if (RES_COUNT !== 16'd8) begin tests_failed++; $display("FAIL fullpop_res_count got %0d exp 8", RES_COUNT); end
    tests_run++; if (OVERFLOW !== 1'b1) begin tests_failed++; $display("FAIL fullpop_ovf got %b exp 1", OVERFLOW); end
    OUT_READY = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tests_run++; if (OUT_DATA !== 32'h20 + 32'(i)) begin tests_failed++; $display("FAIL fullpop_drain_%0d got %h exp %h", i, OUT_DATA, 32'h20 + 32'(i)); end
      cycle();
    end
    OUT_READY = 1'b0;
    tests_run++; if (EMPTY !== 1'b1) begin tests_failed++; $display("FAIL fullpop_empty got %b exp 1", EMPTY); end
  endtask

  task automatic test_clear();
    do_reset();
    fill8(32'h30);
    IN_VALID = 1'b1; DATA_IN = 32'hDEADBEEF;
    cycle();
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    OUT_READY = 1'b0;
    tests_run++; if (OVERFLOW !== 1'b1 || OUT_DATA !== 32'h34) begin tests_failed++; $display("FAIL clear_pre got ovf=%b head=%h exp 1/00000034", OVERFLOW, OUT_DATA); end
    CLEAR = 1'b1; IN_VALID = 1'b1; DATA_IN = 32'h55; ZERO_IN = 1'b1; OUT_READY = 1'b1;
    cycle();
    CLEAR = 1'b0; IN_VALID = 1'b0; ZERO_IN = 1'b0; OUT_READY = 1'b0;
    tests_run++; if (EMPTY !== 1'b1) begin tests_failed++; $display("FAIL clear_empty got %b exp 1", EMPTY); end
    tests_run++; if (SIGNATURE !== 32'h0) begin tests_failed++; $display("FAIL clear_sig got %h exp 00000000", SIGNATURE); end
    tests_run++; if (RES_COUNT !== 16'd0 || ZERO_COUNT !== 16'd0) begin tests_failed++; $display("FAIL clear_counts got %0d/%0d exp 0/0", RES_COUNT, ZERO_COUNT); end
    tests_run++; if (OVERFLOW !== 1'b0) begin tests_failed++; $display("FAIL clear_ovf got %b exp 0", OVERFLOW); end
    cycle();
    tests_run++; if (EMPTY !== 1'b1 || RES_COUNT !== 16'd0) begin tests_failed++; $display("FAIL clear_lost got empty=%b cnt=%0d exp 1/0", EMPTY, RES_COUNT); end
  endtask

  task automatic test_async_reset();
    do_reset();
    IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DATA_IN = 32'hA0 + 32'(i);
      cycle();
    end
    #3;
    RST_n = 1'b0;
    #1;
    tests_run++; if (EMPTY !== 1'b1 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin tests_failed++; $display("FAIL arst_flags got e/v/r=%b exp 101", {EMPTY, OUT_VALID, IN_READY}); end
    tests_run++; if (SIGNATURE !== 32'h0 || RES_COUNT !== 16'd0) begin tests_failed++; $display("FAIL arst_state got sig=%h cnt=%0d exp 00000000/0", SIGNATURE, RES_COUNT); end
    IN_VALID = 1'b0;
    cycle();
    RST_n = 1'b1;
    IN_VALID = 1'b1; DATA_IN = 32'h00000001; ZERO_IN = 1'b0;
    cycle();
    IN_VALID = 1'b0;
    tests_run++; if (SIGNATURE !== 32'h00000001 || RES_COUNT !== 16'd1) begin tests_failed++; $display("FAIL arst_restart got sig=%h cnt=%0d exp 00000001/1", SIGNATURE, RES_COUNT); end
    tests_run++; if (OUT_DATA !== 32'h00000001) begin tests_failed++; $display("FAIL arst_head got %h exp 00000001", OUT_DATA); end
  endtask

  initial begin
    RST_n = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    DATA_IN = '0; ZERO_IN = 1'b0;
    test_reset();
    test_misr();
    test_fill_overflow();
    test_back_to_back();
    test_full_pop();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
